// File: rtl/pagerank_pkg.sv
// Shared PageRank types and fixed-point constants used by the sweep controller and the update datapath.
package pagerank_pkg;

    localparam int N_DEF     = 16;
    localparam int WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ISSUE,
        ST_DRAIN,
        ST_CHECK,
        ST_DONE
    } state_t;

    // 1/n in unsigned Q0.WIDTH_DEF, saturating at the largest representable value when n == 1.
    function automatic logic [WIDTH_DEF-1:0] recip_q(input int n);
        longint q;
        q = (longint'(1) << WIDTH_DEF) / longint'(n);
        if (q > (longint'(1) << WIDTH_DEF) - 1)
            q = (longint'(1) << WIDTH_DEF) - 1;
        return q[WIDTH_DEF-1:0];
    endfunction

    localparam logic [WIDTH_DEF-1:0] ONE_OVER_N = recip_q(N_DEF);
    // Damping factor 0.85.
    localparam logic [WIDTH_DEF-1:0] D_FACTOR   = 16'hD99A;

endpackage

// File: rtl/pagerank_delta_tracker.sv
// Running maximum of |new - old| over the page results of one sweep; i_clear restarts the sweep.
module pagerank_delta_tracker #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_old,
    input  logic [WIDTH-1:0] i_new,
    output logic [WIDTH-1:0] o_max
);

    logic [WIDTH-1:0] w_delta;
    logic [WIDTH-1:0] r_max;

    // Compare first, so the subtraction can never wrap.
    always_comb begin
        w_delta = (i_new >= i_old) ? (i_new - i_old) : (i_old - i_new);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_max <= '0;
        else if (i_clear)
            r_max <= '0;
        else if (i_valid && (w_delta > r_max))
            r_max <= w_delta;
    end

    assign o_max = r_max;

endmodule

// File: rtl/pagerank_sweep_ctrl.sv
// PageRank sweep scheduler: init, issue pages 0..N-1, gather deltas, repeat until converged or capped.
// Optional PR_SWEEP_STATS_EN adds last_max_delta and sweep_cycles outputs.
module pagerank_sweep_ctrl
    import pagerank_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int IDX_W  = $clog2(N),
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  threshold,
    input  logic [ITER_W-1:0] max_iter,
    output logic              init_pulse,
    output logic              upd_valid,
    output logic [IDX_W-1:0]  upd_page,
    input  logic              upd_ready,
    input  logic              res_valid,
    input  logic [WIDTH-1:0]  res_old,
    input  logic [WIDTH-1:0]  res_new,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_count
`ifdef PR_SWEEP_STATS_EN
    ,
    output logic [WIDTH-1:0]  last_max_delta,
    output logic [15:0]       sweep_cycles
`endif
);

    localparam int CNT_W = $clog2(N + 1);

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_thr;
    logic [ITER_W-1:0]  r_max_iter;
    logic [IDX_W-1:0]   r_issue_idx;
    logic [CNT_W-1:0]   r_res_cnt;
    logic [ITER_W-1:0]  r_iter;
    logic               r_conv;

    logic               w_hs;
    logic               w_res;
    logic               w_clr;
    logic [WIDTH-1:0]   w_max_delta;
    logic [ITER_W-1:0]  w_iter_inc;
    logic               w_hit_thr;
    logic               w_hit_cap;

    assign w_hs       = (r_state == ST_ISSUE) && upd_ready;
    assign w_res      = res_valid && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
    assign w_iter_inc = r_iter + 1'b1;
    assign w_hit_thr  = (w_max_delta <= r_thr);
    assign w_hit_cap  = (w_iter_inc >= r_max_iter);

    pagerank_delta_tracker #(.WIDTH(WIDTH)) u_delta (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clr),
        .i_valid (w_res),
        .i_old   (res_old),
        .i_new   (res_new),
        .o_max   (w_max_delta)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        init_pulse = 1'b0;
        upd_valid  = 1'b0;
        done       = 1'b0;
        w_clr      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_INIT;
                    w_clr  = 1'b1;
                end
            end
            ST_INIT: begin
                init_pulse = 1'b1;
                w_next     = ST_ISSUE;
            end
            ST_ISSUE: begin
                upd_valid = 1'b1;
                if (w_hs && (r_issue_idx == IDX_W'(N - 1)))
                    w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_res_cnt == CNT_W'(N))
                    w_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_hit_thr || w_hit_cap) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_ISSUE;
                    w_clr  = 1'b1;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_thr       <= '0;
            r_max_iter  <= '0;
            r_issue_idx <= '0;
            r_res_cnt   <= '0;
            r_iter      <= '0;
            r_conv      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_thr      <= threshold;
                        r_max_iter <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                        r_iter     <= '0;
                        r_conv     <= 1'b0;
                    end
                end
                ST_INIT: begin
                    r_issue_idx <= '0;
                    r_res_cnt   <= '0;
                end
                ST_ISSUE, ST_DRAIN: begin
                    if (w_hs)
                        r_issue_idx <= r_issue_idx + 1'b1;
                    // A misbehaving datapath cannot push the count past N.
                    if (w_res && (r_res_cnt != CNT_W'(N)))
                        r_res_cnt <= r_res_cnt + 1'b1;
                end
                ST_CHECK: begin
                    r_iter      <= w_iter_inc;
                    r_conv      <= w_hit_thr;
                    r_issue_idx <= '0;
                    r_res_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign upd_page   = r_issue_idx;
    assign busy       = (r_state != ST_IDLE);
    assign converged  = r_conv;
    assign iter_count = r_iter;

`ifdef PR_SWEEP_STATS_EN
    logic [15:0]      r_cyc;
    logic [WIDTH-1:0] r_last_max;
    logic [15:0]      r_sweep_cyc;

    // Counts ISSUE+DRAIN cycles of the current sweep; restarted whenever a sweep is about to begin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cyc       <= '0;
            r_last_max  <= '0;
            r_sweep_cyc <= '0;
        end else begin
            case (r_state)
                ST_INIT: r_cyc <= '0;
                ST_ISSUE, ST_DRAIN: begin
                    if (r_cyc != 16'hFFFF)
                        r_cyc <= r_cyc + 16'd1;
                end
                ST_CHECK: begin
                    r_last_max  <= w_max_delta;
                    r_sweep_cyc <= r_cyc;
                    r_cyc       <= '0;
                end
                default: ;
            endcase
        end
    end

    assign last_max_delta = r_last_max;
    assign sweep_cycles   = r_sweep_cyc;
`endif

endmodule

// File: tb/tb_pagerank_sweep_ctrl.sv
// Bench for pagerank_sweep_ctrl (N=4): behavioural datapath model plus page/result scoreboards.
module tb_pagerank_sweep_ctrl;

    localparam int N      = 4;
    localparam int WIDTH  = 16;
    localparam int IDX_W  = 2;
    localparam int ITER_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  threshold;
    logic [ITER_W-1:0] max_iter;
    logic              init_pulse, upd_valid, upd_ready, res_valid;
    logic [IDX_W-1:0]  upd_page;
    logic [WIDTH-1:0]  res_old, res_new;
    logic              busy, done, converged;
    logic [ITER_W-1:0] iter_count;
`ifdef PR_SWEEP_STATS_EN
    logic [WIDTH-1:0]  last_max_delta;
    logic [15:0]       sweep_cycles;
`endif

    pagerank_sweep_ctrl #(.N(N), .WIDTH(WIDTH), .IDX_W(IDX_W), .ITER_W(ITER_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .threshold  (threshold),
        .max_iter   (max_iter),
        .init_pulse (init_pulse),
        .upd_valid  (upd_valid),
        .upd_page   (upd_page),
        .upd_ready  (upd_ready),
        .res_valid  (res_valid),
        .res_old    (res_old),
        .res_new    (res_new),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .iter_count (iter_count)
`ifdef PR_SWEEP_STATS_EN
        ,
        .last_max_delta (last_max_delta),
        .sweep_cycles   (sweep_cycles)
`endif
    );

    // Datapath model: accepts requests, answers one cycle later, records issued pages and stall violations.
    logic             m_rv = 1'b0, m_rdy = 1'b1, m_hs;
    logic [WIDTH-1:0] m_old = '0, m_new = '0, m_d;
    logic [IDX_W-1:0] m_pg, stall_page = '0;
    logic [ITER_W-1:0] m_sw;
    logic             have_stall = 1'b0;
    logic             t_rv = 1'b0;
    logic [WIDTH-1:0] t_old = '0, t_new = '0;
    bit               rand_ready = 1'b0;
    logic [WIDTH-1:0] delta_tab [0:7];
    logic [IDX_W-1:0] obs_page [0:1023];
    int               hs_total = 0, init_total = 0, stall_err = 0;

    assign res_valid = m_rv | t_rv;
    assign res_old   = t_rv ? t_old : m_old;
    assign res_new   = t_rv ? t_new : m_new;
    assign upd_ready = m_rdy;

    always @(posedge clk) begin
        m_hs = upd_valid && upd_ready;
        m_pg = upd_page;
        m_sw = iter_count;
        if (upd_valid && have_stall && (upd_page !== stall_page)) stall_err++;
        have_stall = upd_valid && !upd_ready;
        stall_page = upd_page;
        if (init_pulse) init_total++;
        #1;
        m_rv = m_hs;
        if (m_hs) begin
            obs_page[hs_total[9:0]] = m_pg;
            hs_total++;
            m_d = delta_tab[m_sw[2:0]];
            if (m_pg != 2'd2) m_d = m_d >> 1;
            m_old = 16'h8000;
            m_new = m_pg[0] ? (m_old - m_d) : (m_old + m_d);
        end
        m_rdy = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    typedef struct { bit conv; int iter; } res_t;
    int   exp_pg_q[$];
    res_t exp_res_q[$];
    int   n_chk = 0, n_pass = 0;

    task automatic set_deltas(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                              input logic [WIDTH-1:0] drest);
        delta_tab[0] = d0;
        delta_tab[1] = d1;
        for (int i = 2; i < 8; i++) delta_tab[i] = drest;
    endtask

    task automatic start_run(input logic [WIDTH-1:0] thr, input logic [ITER_W-1:0] mi);
        @(negedge clk);
        threshold = thr;
        max_iter  = mi;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic push_pages(input int sweeps);
        for (int s = 0; s < sweeps; s++)
            for (int p = 0; p < N; p++) exp_pg_q.push_back(p);
    endtask

    task automatic wait_done(output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; threshold = '0; max_iter = '0;
        set_deltas(16'h0100, 16'h0100, 16'h0100);
        repeat (3) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_chk++; if (upd_valid !== 1'b0) $display("FAIL reset_upd_valid: got %b want 0", upd_valid); else n_pass++;
        n_chk++; if (init_pulse !== 1'b0) $display("FAIL reset_init: got %b want 0", init_pulse); else n_pass++;
        n_chk++; if (converged !== 1'b0) $display("FAIL reset_conv: got %b want 0", converged); else n_pass++;
        n_chk++; if (iter_count !== 8'd0) $display("FAIL reset_iter: got %0d want 0", iter_count); else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_one_sweep;
        bit ok; int cyc, base, i0, k, e; res_t r;
        set_deltas(16'h0100, 16'h0100, 16'h0100);
        base = hs_total; i0 = init_total;
        push_pages(1);
        exp_res_q.push_back('{conv: 1'b1, iter: 1});
        start_run(16'hFFFF, 8'd5);
        wait_done(ok, cyc);
        r = exp_res_q.pop_front();
        n_chk++; if (!ok) $display("FAIL one_done_timeout: got no done want done"); else n_pass++;
        // INIT + N issue + 2 drain + CHECK edges after the accepting edge
        n_chk++; if (cyc !== N + 4) $display("FAIL one_latency: got %0d want %0d", cyc, N + 4); else n_pass++;
        n_chk++; if (converged !== r.conv) $display("FAIL one_conv: got %b want %b", converged, r.conv); else n_pass++;
        n_chk++; if (int'(iter_count) !== r.iter) $display("FAIL one_iter: got %0d want %0d", iter_count, r.iter); else n_pass++;
        n_chk++; if (hs_total - base !== exp_pg_q.size()) $display("FAIL one_page_count: got %0d want %0d", hs_total - base, exp_pg_q.size()); else n_pass++;
        k = 0;
        while (exp_pg_q.size() > 0) begin
            e = exp_pg_q.pop_front();
            n_chk++; if (int'(obs_page[base + k]) !== e) $display("FAIL one_page[%0d]: got %0d want %0d", k, obs_page[base + k], e); else n_pass++;
            k++;
        end
        n_chk++; if (init_total - i0 !== 1) $display("FAIL one_init_count: got %0d want 1", init_total - i0); else n_pass++;
        @(negedge clk);
        n_chk++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL one_done_pulse: got done=%b busy=%b want 0/0", done, busy); else n_pass++;
        n_chk++; if (converged !== 1'b1) $display("FAIL one_conv_hold: got %b want 1", converged); else n_pass++;
    endtask

    task automatic test_iter_cap;
        bit ok; int cyc, base, i0, k, e; res_t r;
        set_deltas(16'h0100, 16'h0200, 16'h0300);
        base = hs_total; i0 = init_total;
        push_pages(3);
        exp_res_q.push_back('{conv: 1'b0, iter: 3});
        start_run(16'h0000, 8'd3);
        wait_done(ok, cyc);
        r = exp_res_q.pop_front();
        n_chk++; if (!ok) $display("FAIL cap_done_timeout: got no done want done"); else n_pass++;
        n_chk++; if (converged !== r.conv) $display("FAIL cap_conv: got %b want %b", converged, r.conv); else n_pass++;
        n_chk++; if (int'(iter_count) !== r.iter) $display("FAIL cap_iter: got %0d want %0d", iter_count, r.iter); else n_pass++;
        n_chk++; if (init_total - i0 !== 1) $display("FAIL cap_init_count: got %0d want 1", init_total - i0); else n_pass++;
        n_chk++; if (hs_total - base !== exp_pg_q.size()) $display("FAIL cap_page_count: got %0d want %0d", hs_total - base, exp_pg_q.size()); else n_pass++;
        k = 0;
        while (exp_pg_q.size() > 0) begin
            e = exp_pg_q.pop_front();
            n_chk++; if (int'(obs_page[base + k]) !== e) $display("FAIL cap_page[%0d]: got %0d want %0d", k, obs_page[base + k], e); else n_pass++;
            k++;
        end
    endtask

    task automatic test_stall;
        bit ok; int cyc, base, se, k, e; res_t r;
        set_deltas(16'h0100, 16'h0100, 16'h0100);
        base = hs_total; se = stall_err;
        rand_ready = 1'b1;
        push_pages(2);
        exp_res_q.push_back('{conv: 1'b0, iter: 2});
        start_run(16'h0000, 8'd2);
        wait_done(ok, cyc);
        rand_ready = 1'b0;
        r = exp_res_q.pop_front();
        n_chk++; if (!ok) $display("FAIL stall_done_timeout: got no done want done"); else n_pass++;
        n_chk++; if (stall_err - se !== 0) $display("FAIL stall_page_stable: got %0d changes want 0", stall_err - se); else n_pass++;
        n_chk++; if (converged !== r.conv || int'(iter_count) !== r.iter) $display("FAIL stall_result: got conv=%b iter=%0d want conv=%b iter=%0d", converged, iter_count, r.conv, r.iter); else n_pass++;
        n_chk++; if (hs_total - base !== exp_pg_q.size()) $display("FAIL stall_page_count: got %0d want %0d", hs_total - base, exp_pg_q.size()); else n_pass++;
        k = 0;
        while (exp_pg_q.size() > 0) begin
            e = exp_pg_q.pop_front();
            n_chk++; if (int'(obs_page[base + k]) !== e) $display("FAIL stall_page[%0d]: got %0d want %0d", k, obs_page[base + k], e); else n_pass++;
            k++;
        end
    endtask

    task automatic test_deltas;
        bit ok; int cyc; res_t r;
        // Sweep maxima 0x100, 0x040, 0x008 against 0x010: converges on sweep 3.
        set_deltas(16'h0100, 16'h0040, 16'h0008);
        exp_res_q.push_back('{conv: 1'b1, iter: 3});
        start_run(16'h0010, 8'd8);
        wait_done(ok, cyc);
        r = exp_res_q.pop_front();
        n_chk++; if (!ok) $display("FAIL delta_done_timeout: got no done want done"); else n_pass++;
        n_chk++; if (converged !== r.conv || int'(iter_count) !== r.iter) $display("FAIL delta_result: got conv=%b iter=%0d want conv=%b iter=%0d", converged, iter_count, r.conv, r.iter); else n_pass++;
`ifdef PR_SWEEP_STATS_EN
        n_chk++; if (last_max_delta !== 16'h0008) $display("FAIL delta_last_max: got %h want 0008", last_max_delta); else n_pass++;
        n_chk++; if (sweep_cycles !== 16'(N + 2)) $display("FAIL delta_sweep_cycles: got %0d want %0d", sweep_cycles, N + 2); else n_pass++;
`endif
        // Max delta exactly equal to threshold counts as converged.
        set_deltas(16'h0010, 16'h0010, 16'h0010);
        exp_res_q.push_back('{conv: 1'b1, iter: 1});
        start_run(16'h0010, 8'd4);
        wait_done(ok, cyc);
        r = exp_res_q.pop_front();
        n_chk++; if (!ok || converged !== r.conv || int'(iter_count) !== r.iter) $display("FAIL delta_equal_thr: got ok=%b conv=%b iter=%0d want conv=%b iter=%0d", ok, converged, iter_count, r.conv, r.iter); else n_pass++;
        // max_iter of zero behaves as one sweep.
        set_deltas(16'h0100, 16'h0100, 16'h0100);
        exp_res_q.push_back('{conv: 1'b0, iter: 1});
        start_run(16'h0000, 8'd0);
        wait_done(ok, cyc);
        r = exp_res_q.pop_front();
        n_chk++; if (!ok || converged !== r.conv || int'(iter_count) !== r.iter) $display("FAIL delta_max_iter0: got ok=%b conv=%b iter=%0d want conv=%b iter=%0d", ok, converged, iter_count, r.conv, r.iter); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit ok; int cyc, base, i0, k, e; res_t r;
        set_deltas(16'h0100, 16'h0100, 16'h0100);
        base = hs_total;
        start_run(16'h0000, 8'd5);
        for (int i = 0; i < 500; i++) begin
            if (hs_total - base >= 2 * N) break;
            @(negedge clk);
        end
        n_chk++; if (hs_total - base !== 2 * N) $display("FAIL mid_reach_drain: got %0d issues want %0d", hs_total - base, 2 * N); else n_pass++;
        n_chk++; if (iter_count !== 8'd1 || upd_valid !== 1'b0 || busy !== 1'b1) $display("FAIL mid_in_drain: got iter=%0d valid=%b busy=%b want 1/0/1", iter_count, upd_valid, busy); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_reset_state: got busy=%b done=%b want 0/0", busy, done); else n_pass++;
        n_chk++; if (iter_count !== 8'd0 || converged !== 1'b0) $display("FAIL mid_reset_counts: got iter=%0d conv=%b want 0/0", iter_count, converged); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        base = hs_total; i0 = init_total;
        push_pages(1);
        exp_res_q.push_back('{conv: 1'b1, iter: 1});
        start_run(16'hFFFF, 8'd1);
        wait_done(ok, cyc);
        r = exp_res_q.pop_front();
        n_chk++; if (!ok || converged !== r.conv || int'(iter_count) !== r.iter) $display("FAIL mid_rerun: got ok=%b conv=%b iter=%0d want conv=%b iter=%0d", ok, converged, iter_count, r.conv, r.iter); else n_pass++;
        n_chk++; if (init_total - i0 !== 1) $display("FAIL mid_rerun_init: got %0d want 1", init_total - i0); else n_pass++;
        n_chk++; if (hs_total - base !== exp_pg_q.size()) $display("FAIL mid_page_count: got %0d want %0d", hs_total - base, exp_pg_q.size()); else n_pass++;
        k = 0;
        while (exp_pg_q.size() > 0) begin
            e = exp_pg_q.pop_front();
            n_chk++; if (int'(obs_page[base + k]) !== e) $display("FAIL mid_page[%0d]: got %0d want %0d", k, obs_page[base + k], e); else n_pass++;
            k++;
        end
    endtask

    task automatic test_ignore;
        bit ok; int cyc, base, i0; res_t r;
        set_deltas(16'h0100, 16'h0100, 16'h0100);
        base = hs_total; i0 = init_total;
        exp_res_q.push_back('{conv: 1'b0, iter: 2});
        start_run(16'h0000, 8'd2);
        repeat (3) @(negedge clk);
        // A restart with different settings mid-run must not be taken.
        threshold = 16'hFFFF; max_iter = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok, cyc);
        r = exp_res_q.pop_front();
        n_chk++; if (!ok || converged !== r.conv || int'(iter_count) !== r.iter) $display("FAIL ign_busy_start: got ok=%b conv=%b iter=%0d want conv=%b iter=%0d", ok, converged, iter_count, r.conv, r.iter); else n_pass++;
        n_chk++; if (init_total - i0 !== 1 || hs_total - base !== 2 * N) $display("FAIL ign_busy_counts: got init=%0d issues=%0d want 1/%0d", init_total - i0, hs_total - base, 2 * N); else n_pass++;
        @(negedge clk);
        t_old = 16'h0000; t_new = 16'hFFFF; t_rv = 1'b1;
        repeat (3) @(negedge clk);
        t_rv = 1'b0;
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || upd_valid !== 1'b0) $display("FAIL ign_idle_res_state: got busy=%b done=%b valid=%b want 0/0/0", busy, done, upd_valid); else n_pass++;
        n_chk++; if (converged !== 1'b0 || iter_count !== 8'd2) $display("FAIL ign_idle_res_hold: got conv=%b iter=%0d want 0/2", converged, iter_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_one_sweep();
        test_iter_cap();
        test_stall();
        test_deltas();
        test_reset_mid();
        test_ignore();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
